// File: rtl/sprite_draw_pkg.sv
// Shared constants for the sprite-draw path: screen/sprite geometry and sequencer state encoding.
package sprite_draw_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int SPRITE_W = 60;
  localparam int SPRITE_H = 60;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_SCAN      = 3'd1;
  localparam state_t ST_ISSUE     = 3'd2;
  localparam state_t ST_WAIT_LOW  = 3'd3;
  localparam state_t ST_WAIT_HIGH = 3'd4;
  localparam state_t ST_ADVANCE   = 3'd5;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lane_coord_gen.sv
// Combinational lane index -> sprite x position, selected base_y and draw legality.
module lane_coord_gen import sprite_draw_pkg::*; #(
  parameter int NUM_LANES  = 2,
  parameter int LANE_X0    = 10,
  parameter int LANE_PITCH = 80,
  parameter int Y_MAX      = 60,
  parameter int LW         = lane_idx_w(NUM_LANES)
) (
  input  logic [LW-1:0]          lane,
  input  logic [NUM_LANES-1:0]   lane_active,
  input  logic [NUM_LANES*7-1:0] lane_y,
  output logic [7:0]             base_x,
  output logic [6:0]             y_sel,
  output logic                   legal
);

  always_comb begin
    base_x = 8'(LANE_X0 + int'(lane) * LANE_PITCH);
    y_sel  = lane_y[7*int'(lane) +: 7];
    legal  = lane_active[lane] && (int'(y_sel) <= Y_MAX);
  end

endmodule

// File: rtl/sprite_draw_sequencer.sv
// Walks note lanes once per frame tick and hands each sprite to the drawer via start_draw/shape_done.
// Optional build macro ERASE_PASS_EN adds an erase sprite at the previous y before each moved draw.
module sprite_draw_sequencer import sprite_draw_pkg::*; #(
  parameter int NUM_LANES  = 2,
  parameter int LANE_X0    = 10,
  parameter int LANE_PITCH = 80,
  parameter int Y_MAX      = 60
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [NUM_LANES-1:0]   lane_active,
  input  logic [NUM_LANES*7-1:0] lane_y,
  input  logic                   shape_done,
  output logic                   start_draw,
  output logic [7:0]             base_x,
  output logic [6:0]             base_y,
  output logic                   sprite_sel,
  output logic                   busy,
  output logic                   pass_done,
  output logic [7:0]             overrun_cnt
);

  localparam int LW = lane_idx_w(NUM_LANES);
  localparam logic [LW-1:0] LAST = LW'(NUM_LANES - 1);

  state_t        state, next_state;
  logic [LW-1:0] lane;
  logic          pending;
  logic [7:0]    coord_x;
  logic [6:0]    coord_y;
  logic          coord_legal;
  logic          need_erase;
  logic          redraw;

  lane_coord_gen #(
    .NUM_LANES (NUM_LANES),
    .LANE_X0   (LANE_X0),
    .LANE_PITCH(LANE_PITCH),
    .Y_MAX     (Y_MAX),
    .LW        (LW)
  ) u_coord (
    .lane       (lane),
    .lane_active(lane_active),
    .lane_y     (lane_y),
    .base_x     (coord_x),
    .y_sel      (coord_y),
    .legal      (coord_legal)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state       <= ST_IDLE;
      lane        <= '0;
      pending     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE && next_state == ST_SCAN)
        lane <= '0;
      else if (state == ST_ADVANCE && lane != LAST)
        lane <= lane + 1'b1;
      // A tick landing on pass_done queues the next pass but is not an overrun.
      if (frame_tick && busy) begin
        pending <= 1'b1;
        if (!pass_done && overrun_cnt != 8'hFF)
          overrun_cnt <= overrun_cnt + 8'd1;
      end else if (state == ST_IDLE && next_state == ST_SCAN) begin
        pending <= 1'b0;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (frame_tick || pending) next_state = ST_SCAN;
      ST_SCAN:      next_state = (coord_legal || need_erase) ? ST_ISSUE : ST_ADVANCE;
      ST_ISSUE:     next_state = ST_WAIT_LOW;
      ST_WAIT_LOW:  if (!shape_done) next_state = ST_WAIT_HIGH;
      ST_WAIT_HIGH: if (shape_done) next_state = redraw ? ST_ISSUE : ST_ADVANCE;
      ST_ADVANCE:   next_state = (lane == LAST) ? ST_IDLE : ST_SCAN;
      default:      next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    start_draw = (state == ST_ISSUE);
    busy       = (state != ST_IDLE);
    pass_done  = (state == ST_ADVANCE) && (lane == LAST);
  end

`ifdef ERASE_PASS_EN
  logic [6:0]           prev_y [NUM_LANES];
  logic [NUM_LANES-1:0] prev_drawn;
  logic                 draw_pend;
  logic [6:0]           y_lat;
  logic                 sel_q;

  assign need_erase = prev_drawn[lane] && (!coord_legal || prev_y[lane] != coord_y);
  assign redraw     = sel_q && draw_pend;
  assign sprite_sel = sel_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      base_x     <= '0;
      base_y     <= '0;
      sel_q      <= 1'b0;
      draw_pend  <= 1'b0;
      y_lat      <= '0;
      prev_drawn <= '0;
      for (int i = 0; i < NUM_LANES; i++) prev_y[i] <= '0;
    end else begin
      if (state == ST_SCAN) begin
        prev_drawn[lane] <= coord_legal;
        y_lat            <= coord_y;
        draw_pend        <= coord_legal && need_erase;
        if (coord_legal || need_erase) begin
          base_x <= coord_x;
          sel_q  <= need_erase;
          base_y <= need_erase ? prev_y[lane] : coord_y;
        end
      end
      // prev_y only moves once the note sprite itself has landed.
      if (state == ST_WAIT_HIGH && shape_done) begin
        if (redraw) begin
          sel_q     <= 1'b0;
          base_y    <= y_lat;
          draw_pend <= 1'b0;
        end else if (!sel_q) begin
          prev_y[lane] <= base_y;
        end
      end
    end
  end
`else
  assign need_erase = 1'b0;
  assign redraw     = 1'b0;
  assign sprite_sel = 1'b0;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      base_x <= '0;
      base_y <= '0;
    end else if (state == ST_SCAN && coord_legal) begin
      base_x <= coord_x;
      base_y <= coord_y;
    end
  end
`endif

endmodule

// File: tb/tb_sprite_draw_sequencer.sv
// Bench for sprite_draw_sequencer: vector table, reset/overrun sequences and randomized passes vs a lane model.
module tb_sprite_draw_sequencer;

  typedef struct {
    int x;
    int y;
    int sel;
    int cyc;
  } draw_t;

  typedef struct {
    logic [1:0] act;
    int y0, y1, len;
    int n, x0, ey0, x1, ey1;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic [1:0]  lane_active = '0;
  logic [13:0] lane_y = '0;
  logic        shape_done = 1'b1;
  logic        start_draw;
  logic [7:0]  base_x;
  logic [6:0]  base_y;
  logic        sprite_sel;
  logic        busy;
  logic        pass_done;
  logic [7:0]  overrun_cnt;

  int    vectors = 0;
  int    miscompares = 0;
  int    cyc = 0;
  int    pd_count = 0;
  int    pd_cyc = 0;
  int    draw_len = 1;
  int    dcnt = 0;
  draw_t drawq[$];
  draw_t expq[$];
`ifdef ERASE_PASS_EN
  int    m_y[2];
  bit    m_drawn[2];
`endif

  sprite_draw_sequencer dut (
    .clock      (clock),
    .resetn     (resetn),
    .frame_tick (frame_tick),
    .lane_active(lane_active),
    .lane_y     (lane_y),
    .shape_done (shape_done),
    .start_draw (start_draw),
    .base_x     (base_x),
    .base_y     (base_y),
    .sprite_sel (sprite_sel),
    .busy       (busy),
    .pass_done  (pass_done),
    .overrun_cnt(overrun_cnt)
  );

  initial forever #5 clock = ~clock;

  // Drawer: goes busy (shape_done low) when it sees start_draw, idle again draw_len cycles later.
  always @(negedge clock) begin
    if (start_draw) dcnt = draw_len;
    else if (dcnt > 0) dcnt--;
    shape_done = (dcnt == 0);
  end

  always @(posedge clock) begin
    cyc++;
    #1;
    if (start_draw) drawq.push_back('{x: int'(base_x), y: int'(base_y), sel: int'(sprite_sel), cyc: cyc});
    if (pass_done) begin
      pd_count++;
      pd_cyc = cyc;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_draw(input string nm, input int i, input int x, input int y, input int sel);
    if (i >= drawq.size()) check({nm, "_missing"}, drawq.size(), i + 1);
    else begin
      check({nm, "_x"}, drawq[i].x, x);
      check({nm, "_y"}, drawq[i].y, y);
      check({nm, "_sel"}, drawq[i].sel, sel);
    end
  endtask

  // Expected draw list for one pass: lanes in order, x from lane position, illegal y skipped.
  function automatic void model_pass(input logic [1:0] act, input int y0, input int y1);
    int  ys[2];
    bit  drawn;
    ys[0] = y0;
    ys[1] = y1;
    expq.delete();
    for (int i = 0; i < 2; i++) begin
      drawn = act[i] && (ys[i] <= 60);
`ifdef ERASE_PASS_EN
      if (m_drawn[i] && (!drawn || m_y[i] != ys[i]))
        expq.push_back('{x: 10 + 80 * i, y: m_y[i], sel: 1, cyc: 0});
      if (drawn) m_y[i] = ys[i];
      m_drawn[i] = drawn;
`endif
      if (drawn) expq.push_back('{x: 10 + 80 * i, y: ys[i], sel: 0, cyc: 0});
    end
  endfunction

  task automatic do_reset();
    resetn = 1'b0;
    frame_tick = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
`ifdef ERASE_PASS_EN
    m_y = '{0, 0};
    m_drawn = '{0, 0};
`endif
  endtask

  task automatic wait_pd(input int n, input int budget);
    int k;
    k = 0;
    while (pd_count < n && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (pd_count < n) check("pass_done_timeout", pd_count, n);
  endtask

  task automatic run_pass(input logic [1:0] act, input int y0, input int y1, input int len, output int lat);
    int t0;
    lane_active = act;
    lane_y = {7'(y1), 7'(y0)};
    draw_len = len;
    drawq.delete();
    pd_count = 0;
    model_pass(act, y0, y1);
    @(negedge clock);
    frame_tick = 1'b1;
    t0 = cyc;
    @(negedge clock);
    frame_tick = 1'b0;
    check("busy_in_pass", busy, 1);
    wait_pd(1, 20000);
    lat = pd_cyc - t0;
    @(negedge clock);
    check("busy_after_done", busy, 0);
    check("pass_done_count", pd_count, 1);
    check("draw_count", drawq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      check_draw("model_draw", i, expq[i].x, expq[i].y, expq[i].sel);
    for (int i = 1; i < drawq.size(); i++)
      check("draw_gap_ge2", int'(drawq[i].cyc - drawq[i-1].cyc >= 2), 1);
  endtask

  initial begin
    vec_t tbl[6];
    int   lat;
    int   k;
    int   y0, y1, len;
    logic [1:0] act;

    tbl[0] = '{2'b11, 20, 35, 3600, 2, 10, 20, 90, 35};
    tbl[1] = '{2'b11, 20, 61, 5, 1, 10, 20, 0, 0};
    tbl[2] = '{2'b00, 20, 35, 5, 0, 0, 0, 0, 0};
    tbl[3] = '{2'b10, 0, 60, 3, 1, 90, 60, 0, 0};
    tbl[4] = '{2'b01, 60, 0, 2, 1, 10, 60, 0, 0};
    tbl[5] = '{2'b11, 127, 61, 4, 0, 0, 0, 0, 0};

    // Reset in the middle of a draw, with a pending tick queued.
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_start_draw", start_draw, 0);
    check("rst_base_x", base_x, 0);
    lane_active = 2'b01;
    lane_y = {7'd0, 7'd30};
    draw_len = 50;
    drawq.delete();
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    k = 0;
    while (drawq.size() == 0 && k < 20) begin
      @(negedge clock);
      k++;
    end
    check("rst_first_draw_seen", drawq.size(), 1);
    repeat (10) @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    resetn = 1'b0;
    @(negedge clock);
    check("midrst_start_draw", start_draw, 0);
    check("midrst_base_x", base_x, 0);
    check("midrst_base_y", base_y, 0);
    check("midrst_sprite_sel", sprite_sel, 0);
    check("midrst_busy", busy, 0);
    check("midrst_pass_done", pass_done, 0);
    check("midrst_overrun", overrun_cnt, 0);
    resetn = 1'b1;
`ifdef ERASE_PASS_EN
    m_y = '{0, 0};
    m_drawn = '{0, 0};
`endif
    drawq.delete();
    pd_count = 0;
    repeat (120) @(negedge clock);
    check("postrst_draws", drawq.size(), 0);
    check("postrst_pass_done", pd_count, 0);

    // Zero active lanes: pass_done four cycles after the tick.
    run_pass(2'b00, 10, 10, 5, lat);
    check("zero_lane_latency", lat, 4);

`ifndef ERASE_PASS_EN
    for (int v = 0; v < 6; v++) begin
      run_pass(tbl[v].act, tbl[v].y0, tbl[v].y1, tbl[v].len, lat);
      check("tbl_n", drawq.size(), tbl[v].n);
      if (tbl[v].n > 0) check_draw("tbl_d0", 0, tbl[v].x0, tbl[v].ey0, 0);
      if (tbl[v].n > 1) check_draw("tbl_d1", 1, tbl[v].x1, tbl[v].ey1, 0);
    end
`endif

    for (int r = 0; r < 20; r++) begin
      act = 2'($urandom_range(0, 3));
      y0 = $urandom_range(0, 75);
      y1 = $urandom_range(0, 75);
      len = $urandom_range(1, 8);
      run_pass(act, y0, y1, len, lat);
    end

`ifdef ERASE_PASS_EN
    do_reset();
    run_pass(2'b01, 20, 0, 4, lat);
    check("erase_p1_n", drawq.size(), 1);
    check_draw("erase_p1", 0, 10, 20, 0);
    run_pass(2'b01, 25, 0, 4, lat);
    check("erase_p2_n", drawq.size(), 2);
    check_draw("erase_p2_erase", 0, 10, 20, 1);
    check_draw("erase_p2_draw", 1, 10, 25, 0);
    run_pass(2'b01, 25, 0, 4, lat);
    check("erase_p3_n", drawq.size(), 1);
    check_draw("erase_p3", 0, 10, 25, 0);
`endif

    // Overrun: three ticks during a pass give one extra pass; a long burst saturates.
    do_reset();
    lane_active = 2'b11;
    lane_y = {7'd35, 7'd20};
    draw_len = 20;
    drawq.delete();
    pd_count = 0;
    @(negedge clock);
    frame_tick = 1'b1;
    @(negedge clock);
    frame_tick = 1'b0;
    for (int t = 0; t < 3; t++) begin
      repeat (8) @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
    end
    check("overrun_3", overrun_cnt, 3);
    wait_pd(2, 500);
    repeat (60) @(negedge clock);
    check("overrun_passes", pd_count, 2);
    check("overrun_draws", drawq.size(), 4);
    check("overrun_idle", busy, 0);

    lane_active = 2'b01;
    draw_len = 400;
    pd_count = 0;
    @(negedge clock);
    frame_tick = 1'b1;
    repeat (301) @(negedge clock);
    frame_tick = 1'b0;
    check("overrun_sat", overrun_cnt, 255);
    wait_pd(2, 2000);
    repeat (10) @(negedge clock);
    check("overrun_sat_hold", overrun_cnt, 255);
    check("sat_passes", pd_count, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
